// File: rtl/csr_pkg.sv
// Shared CSR index map, mstatus field positions and reset constants.
package csr_pkg;

  localparam int CSR_IDX_W = 3;
  typedef logic [CSR_IDX_W-1:0] csr_idx_t;

  localparam csr_idx_t CSR_MSTATUS   = 3'd0;
  localparam csr_idx_t CSR_MTVEC     = 3'd1;
  localparam csr_idx_t CSR_MEPC      = 3'd2;
  localparam csr_idx_t CSR_MCAUSE    = 3'd3;
  localparam csr_idx_t CSR_MVENDORID = 3'd4;
  localparam csr_idx_t CSR_MARCHID   = 3'd5;
  localparam csr_idx_t CSR_MCYCLE    = 3'd6;
  localparam csr_idx_t CSR_MINSTRET  = 3'd7;

  localparam int MST_MIE    = 3;
  localparam int MST_MPIE   = 7;
  localparam int MST_MPP_LO = 11;
  localparam int MST_MPP_HI = 12;

  localparam logic [63:0] RST_MSTATUS = 64'h0000_000A_0000_1800;
  localparam logic [63:0] RST_MVENDOR = 64'h7973_7978_015F_DEA8;
  localparam logic [63:0] RST_MARCH   = 64'h4C4A_5100_0CA0_E255;

endpackage

// File: rtl/csr_wr_arbiter.sv
// Lowest-channel-wins write selector for a single CSR index.
module csr_wr_arbiter
  import csr_pkg::*;
#(
  parameter int WR_CH  = 2,
  parameter int CSR_W  = 3,
  parameter int BITS_W = 64
) (
  input  logic [WR_CH-1:0]        wr_en_i,
  input  logic [WR_CH*CSR_W-1:0]  wr_idx_i,
  input  logic [WR_CH*BITS_W-1:0] wr_data_i,
  input  logic [CSR_W-1:0]        tgt_i,
  output logic                    hit_o,
  output logic [BITS_W-1:0]       data_o
);

  // Scan high to low so the lowest matching channel is the last to assign.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int c = WR_CH - 1; c >= 0; c--) begin
      if (wr_en_i[c] && wr_idx_i[c*CSR_W +: CSR_W] == tgt_i) begin
        hit_o  = 1'b1;
        data_o = wr_data_i[c*BITS_W +: BITS_W];
      end
    end
  end

endmodule

// File: rtl/csr_file_mp.sv
// Multi-port machine CSR file with counters and trap/mret sequencing.
// Optional same-cycle write forwarding: YSYX_23060136_CSR_BYPASS_EN.
module csr_file_mp
  import csr_pkg::*;
#(
  parameter int BITS_W   = 64,
  parameter int CSR_NUM  = 8,
  parameter int WR_CH    = 2,
  parameter int RD_PORTS = 2,
  parameter int RET_W    = 2,
  localparam int CSR_W   = $clog2(CSR_NUM)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RD_PORTS*CSR_W-1:0]  rd_idx,
  output logic [RD_PORTS*BITS_W-1:0] rd_data,
  input  logic [WR_CH-1:0]           wr_en,
  input  logic [WR_CH*CSR_W-1:0]     wr_idx,
  input  logic [WR_CH*BITS_W-1:0]    wr_data,
  input  logic                       trap_valid,
  input  logic [BITS_W-1:0]          trap_pc,
  input  logic [BITS_W-1:0]          trap_cause,
  input  logic                       mret_valid,
  input  logic [RET_W-1:0]           retire_cnt,
  output logic [BITS_W-1:0]          mtvec_o,
  output logic [BITS_W-1:0]          mepc_o,
  output logic                       mie_o
);

  logic [BITS_W-1:0] mstatus_q, mstatus_d;
  logic [BITS_W-1:0] mtvec_q, mtvec_d;
  logic [BITS_W-1:0] mepc_q, mepc_d;
  logic [BITS_W-1:0] mcause_q, mcause_d;
  logic [BITS_W-1:0] mcycle_q, mcycle_d;
  logic [BITS_W-1:0] minstret_q, minstret_d;

  logic [CSR_NUM-1:0] hit;
  logic [BITS_W-1:0]  wdata [CSR_NUM];
  logic [BITS_W-1:0]  rv    [CSR_NUM];
  logic               trap, mret;
  logic [CSR_W-1:0]   ridx;
  logic [BITS_W-1:0]  rval;

  for (genvar i = 0; i < CSR_NUM; i++) begin : g_arb
    csr_wr_arbiter #(
      .WR_CH  (WR_CH),
      .CSR_W  (CSR_W),
      .BITS_W (BITS_W)
    ) u_arb (
      .wr_en_i   (wr_en),
      .wr_idx_i  (wr_idx),
      .wr_data_i (wr_data),
      .tgt_i     (CSR_W'(i)),
      .hit_o     (hit[i]),
      .data_o    (wdata[i])
    );
  end

  assign trap = trap_valid;
  assign mret = mret_valid & ~trap_valid;

  always_comb begin
    mstatus_d = mstatus_q;
    if (trap) begin
      mstatus_d[MST_MPIE] = mstatus_q[MST_MIE];
      mstatus_d[MST_MIE]  = 1'b0;
      mstatus_d[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end else if (mret) begin
      mstatus_d[MST_MIE]  = mstatus_q[MST_MPIE];
      mstatus_d[MST_MPIE] = 1'b1;
      mstatus_d[MST_MPP_HI:MST_MPP_LO] = 2'b11;
    end else if (hit[CSR_MSTATUS]) begin
      mstatus_d = wdata[CSR_MSTATUS];
    end
  end

  always_comb begin
    mtvec_d = hit[CSR_MTVEC] ? wdata[CSR_MTVEC] : mtvec_q;
    mepc_d  = mepc_q;
    mcause_d = mcause_q;
    if (trap) begin
      mepc_d   = trap_pc;
      mcause_d = trap_cause;
    end else begin
      if (hit[CSR_MEPC])   mepc_d   = wdata[CSR_MEPC];
      if (hit[CSR_MCAUSE]) mcause_d = wdata[CSR_MCAUSE];
    end
  end

  // A software load of a counter replaces that cycle's increment.
  always_comb begin
    mcycle_d = hit[CSR_MCYCLE] ? wdata[CSR_MCYCLE]
                               : mcycle_q + BITS_W'(1);
    minstret_d = hit[CSR_MINSTRET] ? wdata[CSR_MINSTRET]
                                   : minstret_q + BITS_W'(retire_cnt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mstatus_q  <= BITS_W'(RST_MSTATUS);
      mtvec_q    <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  always_comb begin
    for (int i = 0; i < CSR_NUM; i++) rv[i] = '0;
    rv[CSR_MSTATUS]   = mstatus_q;
    rv[CSR_MTVEC]     = mtvec_q;
    rv[CSR_MEPC]      = mepc_q;
    rv[CSR_MCAUSE]    = mcause_q;
    rv[CSR_MVENDORID] = BITS_W'(RST_MVENDOR);
    rv[CSR_MARCHID]   = BITS_W'(RST_MARCH);
    rv[CSR_MCYCLE]    = mcycle_q;
    rv[CSR_MINSTRET]  = minstret_q;
  end

`ifdef YSYX_23060136_CSR_BYPASS_EN
  logic [CSR_NUM-1:0] fwd;

  // Forward only writes that will actually land in the register.
  always_comb begin
    fwd = hit;
    fwd[CSR_MVENDORID] = 1'b0;
    fwd[CSR_MARCHID]   = 1'b0;
    if (trap) begin
      fwd[CSR_MSTATUS] = 1'b0;
      fwd[CSR_MEPC]    = 1'b0;
      fwd[CSR_MCAUSE]  = 1'b0;
    end
    if (mret) fwd[CSR_MSTATUS] = 1'b0;
  end
`endif

  always_comb begin
    rd_data = '0;
    ridx    = '0;
    rval    = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      ridx = rd_idx[p*CSR_W +: CSR_W];
      rval = (int'(ridx) < CSR_NUM) ? rv[ridx] : '0;
`ifdef YSYX_23060136_CSR_BYPASS_EN
      if (int'(ridx) < CSR_NUM && fwd[ridx]) rval = wdata[ridx];
`endif
      rd_data[p*BITS_W +: BITS_W] = rval;
    end
  end

  logic unused_ro;
  assign unused_ro = ^{hit[CSR_MVENDORID], hit[CSR_MARCHID],
                       wdata[CSR_MVENDORID], wdata[CSR_MARCHID]};

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;
  assign mie_o   = mstatus_q[MST_MIE];

endmodule
